// File: rtl/sense_detector_if.sv
// Sample/pace inputs and beat outputs of sense_detector, bundled as one port.
// The master drives the electrogram and pace; the slave (the detector) reports beats.
interface sense_detector_if #(
    parameter int unsigned SAMPLE_W = 12
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] sense_threshold;
    logic                pace_in;
    logic                heartbeat_out;
    logic                refractory;
    logic [15:0]         beat_count;

    modport master (
        output sample_valid,
        output sample,
        output sense_threshold,
        output pace_in,
        input  heartbeat_out,
        input  refractory,
        input  beat_count
    );

    modport slave (
        input  sample_valid,
        input  sample,
        input  sense_threshold,
        input  pace_in,
        output heartbeat_out,
        output refractory,
        output beat_count
    );
endinterface

// File: rtl/sense_detector.sv
// Electrogram beat detector: debounce, refractory, pace blanking and a saturating beat count.
// Defining SENSE_HYST_EN lowers the re-arm level to sense_threshold - HYST.
module sense_detector #(
    parameter int unsigned SAMPLE_W       = 12,
    parameter int unsigned DEBOUNCE       = 3,
    parameter int unsigned REFRACT_CYCLES = 200,
    parameter int unsigned BLANK_CYCLES   = 40,
    parameter int unsigned HYST           = 64
) (
    input  logic           clk,
    input  logic           rst,
    sense_detector_if.slave bus
);
    localparam int unsigned DebW   = $clog2(DEBOUNCE) + 1;
    localparam int unsigned RefMax = (REFRACT_CYCLES > BLANK_CYCLES) ? REFRACT_CYCLES
                                                                     : BLANK_CYCLES;
    localparam int unsigned RefW   = $clog2(RefMax) + 1;

    localparam logic [DebW-1:0] DebTarget = DebW'(DEBOUNCE);
    localparam logic [DebW-1:0] DebOne    = DebW'(1);
    localparam logic [RefW-1:0] RefLoad   = RefW'(REFRACT_CYCLES);
    localparam logic [RefW-1:0] BlankLoad = RefW'(BLANK_CYCLES);
    localparam logic [RefW-1:0] RefOne    = RefW'(1);

    if (DEBOUNCE < 1 || DEBOUNCE > 15 || REFRACT_CYCLES < 1 || BLANK_CYCLES < 1 ||
        HYST >= (1 << (SAMPLE_W + 1))) begin : g_bad_param
        $error("sense_detector: parameter out of range");
    end

    typedef enum logic [2:0] {
        StSense,
        StConfirm,
        StRefract,
        StWaitLow,
        StBlank
    } state_e;

    state_e          state_q, state_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
    logic            hb_q, hb_d;
    logic            refr_q, refr_d;
    logic [15:0]     beat_count_q, beat_count_d;

    logic            qualify;
    logic            rearm;
    logic            declare;
    logic [DebW-1:0] deb_inc;
    logic [SAMPLE_W-1:0] rearm_level;

`ifdef SENSE_HYST_EN
    localparam logic [SAMPLE_W:0] HystW = (SAMPLE_W + 1)'(HYST);
    logic [SAMPLE_W:0] rearm_diff;

    // A borrow out of the subtraction means threshold < HYST: clamp to 0 (never re-arms).
    assign rearm_diff  = {1'b0, bus.sense_threshold} - HystW;
    assign rearm_level = rearm_diff[SAMPLE_W] ? '0 : rearm_diff[SAMPLE_W-1:0];
`else
    assign rearm_level = bus.sense_threshold;
`endif

    assign qualify = bus.sample_valid && (bus.sample >= bus.sense_threshold);
    assign rearm   = bus.sample_valid && (bus.sample < rearm_level);
    assign deb_inc = deb_cnt_q + DebOne;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        ref_cnt_d = ref_cnt_q;
        declare   = 1'b0;

        if (bus.pace_in) begin
            // Pace wins over everything, including a debounce completing this cycle.
            state_d   = StBlank;
            ref_cnt_d = BlankLoad;
            deb_cnt_d = '0;
        end else begin
            case (state_q)
                StSense: begin
                    if (qualify) begin
                        if (DEBOUNCE == 1) begin
                            declare = 1'b1;
                        end else begin
                            deb_cnt_d = DebOne;
                            state_d   = StConfirm;
                        end
                    end
                end
                StConfirm: begin
                    if (qualify) begin
                        if (deb_inc == DebTarget) begin
                            declare = 1'b1;
                        end else begin
                            deb_cnt_d = deb_inc;
                        end
                    end else if (bus.sample_valid) begin
                        deb_cnt_d = '0;
                        state_d   = StSense;
                    end
                end
                StRefract, StBlank: begin
                    ref_cnt_d = ref_cnt_q - RefOne;
                    if (ref_cnt_q <= RefOne) begin
                        ref_cnt_d = '0;
                        state_d   = StWaitLow;
                    end
                end
                StWaitLow: begin
                    if (rearm) begin
                        state_d = StSense;
                    end
                end
                default: begin
                    state_d   = StSense;
                    deb_cnt_d = '0;
                    ref_cnt_d = '0;
                end
            endcase

            if (declare) begin
                state_d   = StRefract;
                ref_cnt_d = RefLoad;
                deb_cnt_d = '0;
            end
        end
    end

    always_comb begin
        hb_d         = declare;
        refr_d       = (state_d == StRefract) || (state_d == StBlank);
        beat_count_d = beat_count_q;
        if (declare && (beat_count_q != 16'hFFFF)) begin
            beat_count_d = beat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSense;
            deb_cnt_q    <= '0;
            ref_cnt_q    <= '0;
            hb_q         <= 1'b0;
            refr_q       <= 1'b0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            hb_q         <= hb_d;
            refr_q       <= refr_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign bus.heartbeat_out = hb_q;
    assign bus.refractory    = refr_q;
    assign bus.beat_count    = beat_count_q;
endmodule

// File: tb/tb_sense_detector.sv
// Bench for sense_detector: vector table, directed corner sequences, then random stimulus
// against a hold-off/armed/run-length model of the detector.
module tb_sense_detector;
    localparam int unsigned SW  = 12;
    localparam int unsigned DEB = 3;
    localparam int unsigned REF = 200;
    localparam int unsigned BLK = 40;
    localparam int unsigned HYS = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sense_detector_if #(.SAMPLE_W(SW)) bus ();

    sense_detector #(
        .SAMPLE_W      (SW),
        .DEBOUNCE      (DEB),
        .REFRACT_CYCLES(REF),
        .BLANK_CYCLES  (BLK),
        .HYST          (HYS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: cycles of hold-off left, armed (seen a low since last beat/pace), run length.
    int m_hold  = 0;
    int m_run   = 0;
    bit m_armed = 1'b1;
    int m_count = 0;
    bit m_hb    = 1'b0;

    typedef struct {
        bit v;
        int s;
        bit p;
        bit r;
        bit hb;
        bit refr;
        int cnt;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(bit v, int s, bit p, bit r, bit hb, bit refr, int cnt);
        vec_t e;
        e.v = v; e.s = s; e.p = p; e.r = r; e.hb = hb; e.refr = refr; e.cnt = cnt;
        return e;
    endfunction

    function automatic int rearm_of(int thr);
`ifdef SENSE_HYST_EN
        return (thr >= int'(HYS)) ? thr - int'(HYS) : 0;
`else
        return thr;
`endif
    endfunction

    function automatic void model_update(bit v, int s, int thr, bit p, bit r);
        m_hb = 1'b0;
        if (r) begin
            m_hold = 0; m_run = 0; m_armed = 1'b1; m_count = 0;
        end else if (p) begin
            m_hold = int'(BLK); m_run = 0; m_armed = 1'b0;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (v) begin
            if (!m_armed) begin
                if (s < rearm_of(thr)) m_armed = 1'b1;
            end else if (s >= thr) begin
                m_run++;
                if (m_run == int'(DEB)) begin
                    m_hb = 1'b1; m_run = 0; m_hold = int'(REF); m_armed = 1'b0;
                    if (m_count < 65535) m_count++;
                end
            end else begin
                m_run = 0;
            end
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input bit v, input int s, input bit p, input bit r);
        bus.sample_valid = v;
        bus.sample       = SW'(s);
        bus.pace_in      = p;
        rst              = r;
        @(posedge clk);
        model_update(v, s, int'(bus.sense_threshold), p, r);
        #1;
    endtask

    task automatic beat3();
        for (int i = 0; i < 3; i++) step(1'b1, 1200, 1'b0, 1'b0);
    endtask

    // Counts cycles refractory stays high from now on, stepping idle cycles; bounded.
    task automatic count_refr(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!bus.refractory) break;
            n++;
            step(1'b0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int n;
        int pulses;
        int thr;
        int s;
        bit v;
        bit p;
        bit r;

        bus.sample_valid    = 1'b0;
        bus.sample          = '0;
        bus.sense_threshold = SW'(1000);
        bus.pace_in         = 1'b0;
        rst                 = 1'b1;

        // Beat detection, broken runs with gaps, pace on the completing sample.
        tbl[0]  = mk(0,    0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1,  500, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1200, 0, 0, 1, 1, 1);
        tbl[5]  = mk(0,    0, 0, 0, 0, 1, 1);
        tbl[6]  = mk(0,    0, 0, 1, 0, 0, 0);
        tbl[7]  = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0,    0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[10] = mk(0,    0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1,  900, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[13] = mk(0,    0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[15] = mk(1,  900, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 1200, 0, 0, 1, 1, 1);
        tbl[19] = mk(0,    0, 0, 1, 0, 0, 0);
        tbl[20] = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 1200, 0, 0, 0, 0, 0);
        tbl[22] = mk(1, 1200, 1, 0, 0, 1, 0);
        tbl[23] = mk(0,    0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].p, tbl[i].r);
            check($sformatf("vec%0d_hb", i), int'(bus.heartbeat_out), int'(tbl[i].hb));
            check($sformatf("vec%0d_refr", i), int'(bus.refractory), int'(tbl[i].refr));
            check($sformatf("vec%0d_cnt", i), int'(bus.beat_count), tbl[i].cnt);
        end

        // Refractory length after a sensed beat.
        step(1'b0, 0, 1'b0, 1'b1);
        beat3();
        check("beat_hb", int'(bus.heartbeat_out), 1);
        count_refr(n);
        check("refract_len", n, int'(REF));

        // Sustained high signal never re-triggers; one low sample re-arms.
        step(1'b0, 0, 1'b0, 1'b1);
        beat3();
        pulses = 0;
        for (int i = 0; i < int'(REF) + 50; i++) begin
            step(1'b1, 1200, 1'b0, 1'b0);
            if (bus.heartbeat_out) pulses++;
        end
        check("sustained_pulses", pulses, 0);
        step(1'b1, 999, 1'b0, 1'b0);
        beat3();
`ifdef SENSE_HYST_EN
        check("rearm999_hb", int'(bus.heartbeat_out), 0);
        check("rearm999_cnt", int'(bus.beat_count), 1);
`else
        check("rearm999_hb", int'(bus.heartbeat_out), 1);
        check("rearm999_cnt", int'(bus.beat_count), 2);
`endif

        // Pace during CONFIRM: blanking, then WAIT_LOW ignores highs until a low.
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 1200, 1'b0, 1'b0);
        step(1'b1, 1200, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        count_refr(n);
        check("blank_len", n, int'(BLK));
        beat3();
        check("waitlow_hb", int'(bus.heartbeat_out), 0);
        check("waitlow_cnt", int'(bus.beat_count), 0);
        step(1'b1, 900, 1'b0, 1'b0);
        beat3();
        check("after_blank_hb", int'(bus.heartbeat_out), 1);

        // Reset in the middle of refractory.
        step(1'b0, 0, 1'b0, 1'b1);
        beat3();
        for (int i = 0; i < 50; i++) step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        check("midrst_refr", int'(bus.refractory), 0);
        check("midrst_cnt", int'(bus.beat_count), 0);
        beat3();
        check("postrst_hb", int'(bus.heartbeat_out), 1);
        check("postrst_cnt", int'(bus.beat_count), 1);

        // Re-arm level: 950 re-arms only without hysteresis, 935 re-arms in both builds.
        step(1'b0, 0, 1'b0, 1'b1);
        beat3();
        count_refr(n);
        step(1'b1, 950, 1'b0, 1'b0);
        beat3();
`ifdef SENSE_HYST_EN
        check("hyst950_hb", int'(bus.heartbeat_out), 0);
        step(1'b1, 935, 1'b0, 1'b0);
        beat3();
        check("hyst935_hb", int'(bus.heartbeat_out), 1);
`else
        check("hyst950_hb", int'(bus.heartbeat_out), 1);
`endif

        // Saturation: preload the counter near the top instead of sensing 65535 beats.
        step(1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        force dut.beat_count_q = 16'hFFFE;
        #1;
        release dut.beat_count_q;
        m_count = 65534;
        beat3();
        check("sat_fffe_to_ffff", int'(bus.beat_count), 65535);
        count_refr(n);
        step(1'b1, 900, 1'b0, 1'b0);
        beat3();
        check("sat_hb", int'(bus.heartbeat_out), 1);
        check("sat_hold", int'(bus.beat_count), 65535);

        // Random stimulus against the model.
        step(1'b0, 0, 1'b0, 1'b1);
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 499) == 0) bus.sense_threshold = SW'($urandom_range(0, 4095));
            thr = int'(bus.sense_threshold);
            v   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                s = int'($urandom_range(0, 4095));
            end else begin
                s = thr + int'($urandom_range(0, 160)) - 80;
                if (s < 0) s = 0;
                if (s > 4095) s = 4095;
            end
            p = ($urandom_range(0, 199) == 0);
            r = ($urandom_range(0, 1999) == 0);
            step(v, s, p, r);
            check("rand_hb", int'(bus.heartbeat_out), int'(m_hb));
            check("rand_refr", int'(bus.refractory), int'(m_hold > 0));
            check("rand_cnt", int'(bus.beat_count), m_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sense_detector.md
Name: sense_detector

Overview:
- Sensing front-end on the far side of the pacing loop.
- Converts a sampled cardiac electrogram into the single-cycle `heartbeat` pulse that the pacing timer consumes.
- Takes the pacer's pace output back in, so the pacing artifact is blanked and never reported as a natural beat.
- Provides debounce, refractory and re-arm logic, plus a saturating count of sensed beats.

Parameters:
- SAMPLE_W, 12, sample and threshold width in bits (unsigned).
- DEBOUNCE, 3, consecutive qualifying valid samples required to declare a beat (1..15).
- REFRACT_CYCLES, 200, clk cycles of refractory after a sensed beat (>=1).
- BLANK_CYCLES, 40, clk cycles of blanking after a pace pulse (>=1).
- HYST, 64, re-arm hysteresis in sample LSBs. Used only when SENSE_HYST_EN is defined.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- sample_valid  in  1  sample qualifier, one new sample per asserted cycle
- sample  in  SAMPLE_W  unsigned electrogram sample
- sense_threshold  in  SAMPLE_W  detection threshold, sampled every cycle
- pace_in  in  1  pace pulse from the pacing timer (level; any high cycle counts)
- heartbeat_out  out  1  one-cycle sensed-beat pulse, drives the pacer's heartbeat input
- refractory  out  1  high while in BLANK or REFRACT
- beat_count  out  16  saturating count of heartbeat_out pulses

Behaviour:
- Reset:
  - Synchronous and active-high; overrides everything, including mid-operation.
  - On the next edge: state=SENSE, heartbeat_out=0, refractory=0, beat_count=0, all internal counters 0.
- Qualifying sample: sample_valid=1 and sample >= sense_threshold.
- Re-arm sample: sample_valid=1 and sample < re-arm level. The re-arm level is sense_threshold, or as set under Optional Feature.
- Cycles with sample_valid=0 are ignored by SENSE/CONFIRM/WAIT_LOW: they neither count nor break a run.
- States:
  - SENSE: a qualifying sample sets deb_cnt=1. If DEBOUNCE==1, declare the beat immediately; otherwise go to CONFIRM.
  - CONFIRM:
    - A qualifying sample increments deb_cnt.
    - When deb_cnt reaches DEBOUNCE, declare the beat.
    - A valid non-qualifying sample clears deb_cnt and returns to SENSE.
  - Beat declared:
    - heartbeat_out=1 for exactly the cycle after the edge that registered the DEBOUNCE-th sample.
    - beat_count increments, saturating at 0xFFFF.
    - Go to REFRACT with ref_cnt loaded to REFRACT_CYCLES.
  - REFRACT: ref_cnt decrements each cycle and samples are ignored. When it reaches 0, go to WAIT_LOW.
  - WAIT_LOW: wait for a re-arm sample, then go to SENSE. Qualifying samples here are ignored, so a sustained high signal never re-triggers.
  - BLANK: ref_cnt decrements each cycle. When it reaches 0, go to WAIT_LOW.
- pace_in priority:
  - pace_in=1 has priority over every state and over a simultaneously completing debounce.
  - Go to BLANK, load ref_cnt=BLANK_CYCLES, clear deb_cnt.
  - No heartbeat_out and no beat_count change.
  - pace_in during BLANK reloads the counter. pace_in during REFRACT also moves to BLANK.
- refractory is registered and equals (state==BLANK || state==REFRACT).
- Counters are sized by $clog2 of their parameter + 1; no wrap is possible.
- A sense_threshold change takes effect on the next compare; deb_cnt is not cleared.

Optional Feature:
- Macro: SENSE_HYST_EN.
- Defined: re-arm level = sense_threshold - HYST, computed at SAMPLE_W+1 bits. If sense_threshold < HYST, the re-arm level is 0, so re-arm requires sample < 0, which never happens. The block stays in WAIT_LOW until reset or a pace.
  - On pace_in, the block goes to BLANK and then still returns to WAIT_LOW.
- Not defined: re-arm level = sense_threshold. HYST is unused and no extra logic is generated.

Test Plan:
- Beat detection:
  - Stimulus: threshold=1000; valid samples 500,1200,1200,1200.
  - Required: heartbeat_out high exactly one cycle, the cycle after the 3rd 1200 edge; beat_count=1; refractory high 200 cycles.
- Broken run:
  - Stimulus: threshold=1000; samples 1200,1200,900,1200,1200, with sample_valid gaps between samples.
  - Required: no heartbeat_out; beat_count=0.
- Sustained high signal:
  - Stimulus: after a sensed beat, hold 1200 valid through refractory and 50 further cycles.
  - Required: no pulse.
  - Then send one 999 sample followed by 3x1200. Required: one pulse; beat_count=2.
- Pace during a debounce run:
  - Stimulus: pace_in one cycle during CONFIRM (deb_cnt=2); next sample 1200.
  - Required: no pulse; refractory high 40 cycles; then WAIT_LOW.
  - Also drive pace_in on the same cycle as the 3rd qualifying sample. Required: no pulse; beat_count unchanged.
- Reset mid-refractory:
  - Stimulus: rst asserted mid-REFRACT.
  - Required: refractory=0, beat_count=0 on the next edge; 3x1200 after release produce a pulse.
  - Saturation: force beat_count to 0xFFFF via 65535 beats; one more beat must leave it at 0xFFFF.
- Hysteresis:
  - Stimulus: build with SENSE_HYST_EN; threshold=1000; after refractory, sample 950 then 3x1200.
  - Required: no pulse.
  - Then sample 935 then 3x1200. Required: pulse.
  - Without the macro, the 950 sample re-arms.
